// File: rtl/audio_pkg.sv
// Shared definitions for the audio output streaming path.
//   NUM_BEATS        beats per frame
//   SAMPLES_PER_BEAT samples packed into one beat
//   SAMPLE_W         sample width in bits
//   BEAT_W           beat width in bits
//   stream_state_t   streamer FSM states
package audio_pkg;

  localparam int unsigned NUM_BEATS        = 64;
  localparam int unsigned SAMPLES_PER_BEAT = 32;
  localparam int unsigned SAMPLE_W         = 16;
  localparam int unsigned BEAT_W           = 512;

  localparam int unsigned IDX_W        = $clog2(NUM_BEATS);
  localparam int unsigned CNT_W        = $clog2(SAMPLES_PER_BEAT);
  // Sample k of a beat starts at bit k << SAMPLE_SHIFT.
  localparam int unsigned SAMPLE_SHIFT = $clog2(SAMPLE_W);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStream
  } stream_state_t;

endpackage

// File: rtl/beat_serializer.sv
// Holds one beat and presents its samples one at a time, lowest first.
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   load_i        capture beat_i and present sample 0
//   advance_i     step to the next sample of the held beat
//   beat_i        beat to capture
//   sample_data_o registered current sample
//   samp_cnt_o    index of the current sample
//   beat_empty_o  current sample is the last of the beat; the next advance drains it
module beat_serializer
  import audio_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic                advance_i,
  input  logic [BEAT_W-1:0]   beat_i,
  output logic [SAMPLE_W-1:0] sample_data_o,
  output logic [CNT_W-1:0]    samp_cnt_o,
  output logic                beat_empty_o
);

  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LastSamp = CNT_W'(SAMPLES_PER_BEAT - 1);

  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CNT_W-1:0]    samp_cnt_q, samp_cnt_d, samp_nxt;
  logic [SAMPLE_W-1:0] sample_q, sample_d;

  always_comb begin
    samp_nxt   = samp_cnt_q + CntOne;
    beat_d     = beat_q;
    samp_cnt_d = samp_cnt_q;
    sample_d   = sample_q;
    if (load_i) begin
      beat_d     = beat_i;
      samp_cnt_d = '0;
      sample_d   = beat_i[SAMPLE_W-1:0];
    end else if (advance_i) begin
      // Output is registered, so look one sample ahead of the counter.
      samp_cnt_d = samp_nxt;
      sample_d   = beat_q[{samp_nxt, {SAMPLE_SHIFT{1'b0}}} +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      beat_q     <= '0;
      samp_cnt_q <= '0;
      sample_q   <= '0;
    end else begin
      beat_q     <= beat_d;
      samp_cnt_q <= samp_cnt_d;
      sample_q   <= sample_d;
    end
  end

  assign sample_data_o = sample_q;
  assign samp_cnt_o    = samp_cnt_q;
  assign beat_empty_o  = (samp_cnt_q == LastSamp);

endmodule

// File: rtl/audio_output_streamer.sv
// Reads a finished frame out of AudioProcessor beat by beat and streams it as 16-bit samples.
//   clk           clock
//   rst_n         synchronous active-low reset
//   proc_done     processor done level; a rising edge starts a frame
//   output_index  beat address to the processor
//   proc_data_out beat data, valid READ_LATENCY cycles after output_index changes
//   sample_valid  / sample_ready / sample_data / sample_last: sample stream handshake
//   busy          frame in progress
//   frame_done    one-cycle pulse after the final handshake of a frame
//   overrun       sticky: start requested while busy; clear_overrun clears it
module audio_output_streamer
  import audio_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                proc_done,
  output logic [IDX_W-1:0]    output_index,
  input  logic [BEAT_W-1:0]   proc_data_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_last,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun,
  input  logic                clear_overrun
);

  localparam logic [1:0]       LatLast    = 2'(READ_LATENCY);
  localparam logic [IDX_W-1:0] LastBeat   = IDX_W'(NUM_BEATS - 1);
  localparam logic [IDX_W-1:0] IdxOne     = IDX_W'(1);
  localparam logic [CNT_W-1:0] PenultSamp = CNT_W'(SAMPLES_PER_BEAT - 2);

  stream_state_t    state_q, state_d;
  logic             done_q, armed_q;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;

  logic             start_evt, hs, final_hs;
  logic             load, advance, beat_empty;
  logic [CNT_W-1:0] samp_cnt;

  // armed_q blocks a start when proc_done is already high as reset releases;
  // it must be seen low once before a rising edge counts.
  assign start_evt = proc_done & ~done_q & armed_q;
  assign hs        = valid_q & sample_ready;
  assign final_hs  = hs & beat_empty & (beat_cnt_q == LastBeat);

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q & ~clear_overrun;
    load         = 1'b0;
    advance      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_evt) begin
          state_d    = StFetch;
          beat_cnt_d = '0;
          lat_cnt_d  = '0;
        end
      end

      StFetch: begin
        if (start_evt) overrun_d = 1'b1;
        if (lat_cnt_q == LatLast) begin
          load    = 1'b1;
          state_d = StStream;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      StStream: begin
        // A start coinciding with the final handshake restarts cleanly instead of overrunning.
        if (start_evt && !final_hs) overrun_d = 1'b1;
        if (hs) begin
          advance = 1'b1;
          if (beat_empty) begin
            last_d    = 1'b0;
            lat_cnt_d = '0;
            if (beat_cnt_q == LastBeat) begin
              frame_done_d = 1'b1;
              if (start_evt) begin
                state_d    = StFetch;
                beat_cnt_d = '0;
              end else begin
                state_d = StIdle;
              end
            end else begin
              state_d    = StFetch;
              beat_cnt_d = beat_cnt_q + IdxOne;
            end
          end else if (beat_cnt_q == LastBeat && samp_cnt == PenultSamp) begin
            last_d = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StStream);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      done_q       <= 1'b0;
      armed_q      <= 1'b0;
      lat_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= proc_done;
      armed_q      <= armed_q | ~proc_done;
      lat_cnt_q    <= lat_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  beat_serializer u_beat_serializer (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_i        (load),
    .advance_i     (advance),
    .beat_i        (proc_data_out),
    .sample_data_o (sample_data),
    .samp_cnt_o    (samp_cnt),
    .beat_empty_o  (beat_empty)
  );

  assign output_index = beat_cnt_q;
  assign sample_valid = valid_q;
  assign sample_last  = last_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_output_streamer.sv
// Directed bench: three streamers (READ_LATENCY 1, 0, 3) fed by ramp-pattern beat memories
// where beat b sample k holds b*32+k, so frame sample n carries the value n.
module tb_audio_output_streamer;

  logic clk = 1'b0;
  logic rst_n, proc_done, sample_ready, clear_overrun;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0]   idx0, idx1, idx3;
  logic [511:0] pd0, pd1, pd3, m1, m3a, m3b, m3c;
  logic         v0, v1, v3, l0, l1, l3, b0, b1, b3, f0, f1, f3, o0, o1, o3;
  logic [15:0]  d0, d1, d3;

  function automatic logic [511:0] ramp(input logic [5:0] idx);
    logic [511:0] r;
    for (int k = 0; k < 32; k++) r[16*k +: 16] = 16'(int'(idx) * 32 + k);
    return r;
  endfunction

  assign pd0 = ramp(idx0);
  always @(posedge clk) begin
    m1  <= ramp(idx1);
    m3a <= ramp(idx3);
    m3b <= m3a;
    m3c <= m3b;
  end
  assign pd1 = m1;
  assign pd3 = m3c;

  audio_output_streamer #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .proc_done(proc_done), .output_index(idx1),
    .proc_data_out(pd1), .sample_valid(v1), .sample_ready(sample_ready), .sample_data(d1),
    .sample_last(l1), .busy(b1), .frame_done(f1), .overrun(o1), .clear_overrun(clear_overrun)
  );
  audio_output_streamer #(.READ_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .proc_done(proc_done), .output_index(idx0),
    .proc_data_out(pd0), .sample_valid(v0), .sample_ready(sample_ready), .sample_data(d0),
    .sample_last(l0), .busy(b0), .frame_done(f0), .overrun(o0), .clear_overrun(clear_overrun)
  );
  audio_output_streamer #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .proc_done(proc_done), .output_index(idx3),
    .proc_data_out(pd3), .sample_valid(v3), .sample_ready(sample_ready), .sample_data(d3),
    .sample_last(l3), .busy(b3), .frame_done(f3), .overrun(o3), .clear_overrun(clear_overrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; proc_done = 1'b0; sample_ready = 1'b0; clear_overrun = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; proc_done = 1'b1; sample_ready = 1'b1; clear_overrun = 1'b0;
    repeat (3) tick;
    checks++;
    if ({idx1, v1, d1, l1, b1, f1, o1} !== 28'd0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0", {idx1, v1, d1, l1, b1, f1, o1});
    end
    rst_n = 1'b1;
    repeat (5) tick;
    checks++;
    if (b1 !== 1'b0) begin
      errors++;
      $display("FAIL no_start_done_held: busy got %b required 0", b1);
    end
    proc_done = 1'b0;
    tick; tick;
  endtask

  task automatic test_ramp;
    int n = 0, mism = 0, busy_cyc = 0, fd_cnt = 0, first = -1, last_hs = -1, fd_cyc = -1;
    int first_bad = -1;
    sample_ready = 1'b1;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 2300; cyc++) begin
      tick;
      if (cyc == 1) begin
        proc_done = 1'b0;
        checks++;
        if (b1 !== 1'b1 || idx1 !== 6'd0) begin
          errors++;
          $display("FAIL start_busy: busy/index got %b/%0d required 1/0", b1, idx1);
        end
      end
      if (b1) busy_cyc++;
      if (f1) begin fd_cnt++; fd_cyc = cyc; end
      if (v1) begin
        if (first < 0) first = cyc;
        if (d1 !== 16'(n) || l1 !== (n == 2047)) begin
          mism++;
          if (first_bad < 0) first_bad = n;
        end
        n++;
        last_hs = cyc;
      end
    end
    checks++;
    if (first != 3) begin errors++; $display("FAIL ramp_first_valid: got %0d required 3", first); end
    checks++;
    if (n != 2048) begin errors++; $display("FAIL ramp_count: got %0d required 2048", n); end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL ramp_data_last: %0d bad samples, first at %0d, required 0", mism, first_bad);
    end
    checks++;
    if (busy_cyc != 2176) begin
      errors++; $display("FAIL ramp_cycles: got %0d required 2176", busy_cyc);
    end
    checks++;
    if (fd_cnt != 1 || fd_cyc != last_hs + 1) begin
      errors++;
      $display("FAIL ramp_frame_done: pulses %0d at %0d, required 1 at %0d", fd_cnt, fd_cyc,
               last_hs + 1);
    end
  endtask

  task automatic test_random_ready;
    int n = 0, mism = 0, stall_bad = 0, fd_cnt = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic prev_l = 1'b0;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 9000; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      if (prev_stall && (v1 !== 1'b1 || d1 !== prev_d || l1 !== prev_l)) stall_bad++;
      if (f1) fd_cnt++;
      if (fd_cnt > 0) break;
      sample_ready = 1'($urandom_range(0, 1));
      if (v1 && sample_ready) begin
        if (d1 !== 16'(n) || l1 !== (n == 2047)) mism++;
        n++;
      end
      prev_stall = v1 && !sample_ready;
      prev_d = d1;
      prev_l = l1;
    end
    sample_ready = 1'b1;
    checks++;
    if (n != 2048 || fd_cnt != 1) begin
      errors++; $display("FAIL rand_count: got %0d/%0d required 2048/1", n, fd_cnt);
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL rand_order: got %0d bad required 0", mism); end
    checks++;
    if (stall_bad != 0) begin
      errors++; $display("FAIL rand_stall_hold: got %0d violations required 0", stall_bad);
    end
  endtask

  task automatic test_overrun;
    int n = 0, mism = 0, fd_cnt = 0, p1 = -1, p2 = -1;
    sample_ready = 1'b1;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 2400; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      if (cyc == p1 + 1 && p1 > 0) begin
        proc_done = 1'b0;
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b required 1", o1); end
      end
      if (cyc == p2 + 1 && p2 > 0) begin
        proc_done = 1'b0; clear_overrun = 1'b0;
        checks++;
        if (o1 !== 1'b1) begin
          errors++; $display("FAIL overrun_set_wins: got %b required 1", o1);
        end
      end
      if (f1) fd_cnt++;
      if (v1) begin
        if (d1 !== 16'(n)) mism++;
        n++;
      end
      if (v1 && idx1 == 6'd10 && p1 < 0) begin
        checks++;
        if (o1 !== 1'b0) begin
          errors++; $display("FAIL overrun_before: got %b required 0", o1);
        end
        proc_done = 1'b1; p1 = cyc;
      end
      if (v1 && idx1 == 6'd20 && p2 < 0) begin
        proc_done = 1'b1; clear_overrun = 1'b1; p2 = cyc;
      end
    end
    checks++;
    if (n != 2048 || mism != 0 || fd_cnt != 1) begin
      errors++;
      $display("FAIL overrun_frame: count %0d bad %0d fd %0d required 2048 0 1", n, mism, fd_cnt);
    end
    checks++;
    if (o1 !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b required 1", o1); end
    clear_overrun = 1'b1;
    tick;
    clear_overrun = 1'b0;
    checks++;
    if (o1 !== 1'b0) begin errors++; $display("FAIL overrun_cleared: got %b required 0", o1); end
  endtask

  task automatic test_back_to_back;
    logic found = 1'b0;
    sample_ready = 1'b1;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 2400; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      if (v1 && l1) begin
        proc_done = 1'b1;
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL b2b_last_seen: got 0 required 1"); end
    tick;
    proc_done = 1'b0;
    checks++;
    if ({f1, b1, v1, idx1, o1} !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_restart: fd/busy/valid/idx/ovr got %b/%b/%b/%0d/%b required 1/1/0/0/0",
               f1, b1, v1, idx1, o1);
    end
    tick; tick;
    checks++;
    if (v1 !== 1'b1 || d1 !== 16'd0 || o1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first_sample: valid/data/ovr got %b/%0d/%b required 1/0/0", v1, d1, o1);
    end
  endtask

  task automatic test_reset_midframe;
    logic found = 1'b0;
    logic fd_seen = 1'b0;
    int n = 0, mism = 0;
    do_reset;
    sample_ready = 1'b1;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      if (v1 && d1 == 16'd965) begin
        rst_n = 1'b0;
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach_sample: got 0 required 1"); end
    tick;
    checks++;
    if ({idx1, v1, d1, l1, b1, f1, o1} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset_values: got %h required 0", {idx1, v1, d1, l1, b1, f1, o1});
    end
    rst_n = 1'b1;
    repeat (5) begin
      tick;
      if (f1 || b1) fd_seen = 1'b1;
    end
    checks++;
    if (fd_seen) begin errors++; $display("FAIL mid_no_frame_done: got 1 required 0"); end
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      if (v1) begin
        if (d1 !== 16'(n)) mism++;
        n++;
      end
    end
    checks++;
    if (n < 32 || mism != 0) begin
      errors++;
      $display("FAIL mid_restream: count %0d bad %0d required >=32 and 0", n, mism);
    end
  endtask

  task automatic test_latency;
    int exp_first[3] = '{2, 3, 5};
    int exp_bub[3]   = '{1, 2, 4};
    int first[3] = '{-1, -1, -1};
    int bub[3]   = '{-1, -1, -1};
    int gap[3]   = '{0, 0, 0};
    logic [15:0] fdat[3], bdat[3];
    logic vv[3];
    logic [15:0] dd[3];
    do_reset;
    sample_ready = 1'b1;
    proc_done = 1'b1;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      tick;
      if (cyc == 1) proc_done = 1'b0;
      vv[0] = v0; vv[1] = v1; vv[2] = v3;
      dd[0] = d0; dd[1] = d1; dd[2] = d3;
      for (int i = 0; i < 3; i++) begin
        if (vv[i]) begin
          if (first[i] < 0) begin
            first[i] = cyc; fdat[i] = dd[i];
          end else if (gap[i] > 0 && bub[i] < 0) begin
            bub[i] = gap[i]; bdat[i] = dd[i];
          end
          gap[i] = 0;
        end else if (first[i] >= 0) begin
          gap[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] != exp_first[i] || fdat[i] !== 16'd0) begin
        errors++;
        $display("FAIL lat_first_valid[%0d]: cycle/data got %0d/%0d required %0d/0",
                 i, first[i], fdat[i], exp_first[i]);
      end
      checks++;
      if (bub[i] != exp_bub[i] || bdat[i] !== 16'd32) begin
        errors++;
        $display("FAIL lat_bubble[%0d]: len/data got %0d/%0d required %0d/32",
                 i, bub[i], bdat[i], exp_bub[i]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_ramp;
    test_random_ready;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    test_latency;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
